log_mem_ctrl: RTL and testbench

LOG_MEM_CTRL -- requirements
Module: log_mem_ctrl

---
 rtl/log_mem_pkg.sv | 22 ++
 rtl/log_mem_ctrl_edge_detect.sv | 34 +++
 rtl/log_mem_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_log_mem_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_mem_pkg.sv
// ---------------------------------------------------------------------------
// log_mem_pkg
// Shared definitions for the log memory controller: default sample and
// address widths, and the controller state encoding.
// ---------------------------------------------------------------------------
package log_mem_pkg;

  localparam int DEF_NB_DATA = 16;
  localparam int DEF_NB_ADDR = 10;

  // IDLE : nothing in progress, capture may be partial or empty
  // LOG  : capturing samples into memory
  // FULL : capture reached DEPTH entries, waiting for run/read
  // READ : streaming captured samples back out
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOG  = 2'd1,
    ST_FULL = 2'd2,
    ST_READ = 2'd3
  } state_t;

endpackage

// File: rtl/log_mem_ctrl_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a slow level input (toggled button state).
// The edge is the current level compared against a one-cycle-delayed copy.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset, clears the delayed copy
//   level  : level input to watch
//   rise   : high for the cycle in which level is 1 and was 0 one clock ago
// Because the delayed copy resets to 0, a level that is already high when
// reset is released reports a rise on the first clock.
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_d;

  // NOTE: asynchronous reset belongs in the sensitivity list; the reset
  // branch must come first so it overrides the clocked update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/log_mem_ctrl.sv
// ---------------------------------------------------------------------------
// log_mem_ctrl
// Captures a stream of samples into an external synchronous memory and reads
// them back out on request.
//   - i_run rising edge starts a capture; samples strobed by i_valid are
//     written at consecutive addresses until DEPTH entries are stored (FULL)
//     or i_run drops (partial capture, back to IDLE).
//   - i_read rising edge replays the captured entries, one per cycle.
// Ports:
//   i_clock, i_reset      : clock, asynchronous active-high reset
//   i_run, i_read         : level inputs, rising edges start capture/read-out
//   i_valid, i_data       : incoming sample strobe and value
//   o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata : memory port
//                           (read data valid one cycle after the address)
//   o_data, o_data_valid  : read-out sample and strobe
//   o_full                : last capture stored DEPTH entries
//   o_busy                : capture or read-out in progress
// ---------------------------------------------------------------------------
module log_mem_ctrl
  import log_mem_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_ADDR = DEF_NB_ADDR
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_read,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_data_valid,
  output logic               o_full,
  output logic               o_busy
);

  localparam int DEPTH = 1 << NB_ADDR;

  // One extra bit so a full capture (DEPTH entries) is representable.
  typedef logic [NB_ADDR:0] count_t;

  localparam count_t LAST_IDX  = count_t'(DEPTH - 1);
  localparam count_t DEPTH_CNT = count_t'(DEPTH);

  state_t state, state_nxt;
  count_t wr_count;   // entries stored by the current/last capture
  count_t rd_ptr;     // address currently presented during READ

  logic run_rise, read_rise;
  logic start_log, start_read, do_write, do_read;
  logic wr_last, rd_last;

  // -------------------------------------------------------------------------
  // Edge detection on the two button levels
  // -------------------------------------------------------------------------
  edge_detect u_run_edge (
    .clock (i_clock),
    .reset (i_reset),
    .level (i_run),
    .rise  (run_rise)
  );

  edge_detect u_read_edge (
    .clock (i_clock),
    .reset (i_reset),
    .level (i_read),
    .rise  (read_rise)
  );

  assign wr_last = (wr_count == LAST_IDX);
  assign rd_last = (rd_ptr == wr_count - 1'b1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: assigning a default before the case keeps every path driven, so no
  // latch is inferred when a branch leaves the state unchanged.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_FULL: begin
        // A run edge takes priority over a coincident read edge.
        if (run_rise) begin
          state_nxt = ST_LOG;
        end else if (read_rise && (wr_count != '0)) begin
          state_nxt = ST_READ;
        end
      end
      ST_LOG: begin
        // Filling the last entry wins over i_run dropping in the same cycle.
        if (i_valid && wr_last) begin
          state_nxt = ST_FULL;
        end else if (!i_run) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_last) begin
          state_nxt = (wr_count == DEPTH_CNT) ? ST_FULL : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / control decode
  // -------------------------------------------------------------------------
  always_comb begin
    start_log  = 1'b0;
    start_read = 1'b0;
    do_write   = 1'b0;
    do_read    = 1'b0;
    o_busy     = 1'b0;
    case (state)
      ST_IDLE, ST_FULL: begin
        start_log  = run_rise;
        start_read = !run_rise && read_rise && (wr_count != '0);
      end
      ST_LOG: begin
        o_busy   = 1'b1;
        do_write = i_valid;
      end
      ST_READ: begin
        o_busy  = 1'b1;
        do_read = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: counters and registered memory port
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_count     <= '0;
      rd_ptr       <= '0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_data_valid <= 1'b0;
      o_full       <= 1'b0;
    end else begin
      // Write strobe and read-out strobe are each one cycle behind the
      // decision that causes them.
      o_mem_we     <= do_write;
      o_data_valid <= do_read;

      if (start_log) begin
        wr_count <= '0;
        o_full   <= 1'b0;
      end else if (do_write) begin
        wr_count    <= wr_count + 1'b1;
        o_mem_addr  <= wr_count[NB_ADDR-1:0];
        o_mem_wdata <= i_data;
        if (wr_last) begin
          o_full <= 1'b1;
        end
      end

      // The first read address is presented in the first READ cycle; each
      // READ cycle then advances to the next one until the last entry.
      if (start_read) begin
        rd_ptr     <= '0;
        o_mem_addr <= '0;
      end else if (do_read && !rd_last) begin
        rd_ptr     <= rd_ptr + 1'b1;
        o_mem_addr <= rd_ptr[NB_ADDR-1:0] + 1'b1;
      end
    end
  end

  // Read data arrives one cycle after its address, which is exactly the
  // cycle o_data_valid is high; outside those cycles o_data is held at 0.
  assign o_data = o_data_valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_log_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_log_mem_ctrl
// Self-checking bench for log_mem_ctrl with NB_ADDR=3 (DEPTH=8).
// The reference model is the list of samples a capture should retain (the
// first DEPTH samples offered while logging) plus the expected full flag;
// writes and read-outs observed on the DUT are compared against that list.
// ---------------------------------------------------------------------------
module tb_log_mem_ctrl;

  localparam int NB_DATA = 16;
  localparam int NB_ADDR = 3;
  localparam int DEPTH   = 1 << NB_ADDR;

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic               read;
  logic               valid;
  logic [NB_DATA-1:0] data;
  logic               mem_we;
  logic [NB_ADDR-1:0] mem_addr;
  logic [NB_DATA-1:0] mem_wdata;
  logic [NB_DATA-1:0] mem_rdata;
  logic [NB_DATA-1:0] out_data;
  logic               out_valid;
  logic               full;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  log_mem_ctrl #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_run        (run),
    .i_read       (read),
    .i_valid      (valid),
    .i_data       (data),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_data       (out_data),
    .o_data_valid (out_valid),
    .o_full       (full),
    .o_busy       (busy)
  );

  // Synchronous memory: read data valid one cycle after the address.
  logic [NB_DATA-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Monitor: records memory writes and read-out samples at the falling edge.
  int                 cyc = 0;
  int                 wr_addr_q[$];
  logic [NB_DATA-1:0] wr_data_q[$];
  bit                 wr_full_q[$];
  logic [NB_DATA-1:0] rd_data_q[$];
  int                 rd_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
      wr_full_q.push_back(full);
    end
    if (out_valid === 1'b1) begin
      rd_data_q.push_back(out_data);
      rd_cyc_q.push_back(cyc);
    end
  end

  // Reference model state
  logic [NB_DATA-1:0] stim_q[$];
  logic [NB_DATA-1:0] exp_q[$];
  bit                 exp_full = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_full_q.delete();
    rd_data_q.delete();
    rd_cyc_q.delete();
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(NB_DATA'($urandom));
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [2*NB_DATA+NB_ADDR+4:0] outs;
    rst = 1'b1; run = 1'b0; read = 1'b0; valid = 1'b0; data = '0;
    repeat (3) tick();
    outs = {mem_we, mem_addr, mem_wdata, out_data, out_valid, full, busy};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  // Capture the samples in stim_q; i_run drops together with the last one.
  task automatic test_capture(input string name, input bit gaps);
    int n_exp;
    clear_mon();
    exp_q.delete();
    run = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: got busy=%b full=%b expected busy=1 full=0", name, busy, full);
    end
    for (int i = 0; i < stim_q.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          valid = 1'b0;
          tick();
        end
      end
      valid = 1'b1;
      data  = stim_q[i];
      if (i == stim_q.size() - 1) run = 1'b0;
      if (exp_q.size() < DEPTH) exp_q.push_back(stim_q[i]);
      tick();
    end
    valid = 1'b0;
    data  = '0;
    run   = 1'b0;
    repeat (3) tick();
    exp_full = (stim_q.size() >= DEPTH);
    n_exp = exp_q.size();

    n_checks++;
    if (wr_addr_q.size() !== n_exp) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d expected %0d", name, wr_addr_q.size(), n_exp);
    end
    for (int i = 0; i < n_exp && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_q[i] ||
          wr_full_q[i] !== (i == DEPTH - 1)) begin
        n_fail++;
        $display("FAIL %s_write[%0d]: got addr=%0d data=%h full=%b expected addr=%0d data=%h full=%b",
                 name, i, wr_addr_q[i], wr_data_q[i], wr_full_q[i], i, exp_q[i], (i == DEPTH - 1));
      end
    end
    n_checks++;
    if (busy !== 1'b0 || full !== exp_full) begin
      n_fail++;
      $display("FAIL %s_end: got busy=%b full=%b expected busy=0 full=%b", name, busy, full, exp_full);
    end
  endtask

  // Read back the current capture and compare against exp_q.
  task automatic test_readout(input string name);
    int n_exp;
    n_exp = exp_q.size();
    clear_mon();
    read = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy: got %b expected 1", name, busy);
    end
    for (int t = 0; t < DEPTH + 8 && rd_data_q.size() < n_exp; t++) tick();
    read = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (rd_data_q.size() !== n_exp) begin
      n_fail++;
      $display("FAIL %s_count: got %0d expected %0d", name, rd_data_q.size(), n_exp);
    end
    for (int i = 0; i < n_exp && i < rd_data_q.size(); i++) begin
      n_checks++;
      if (rd_data_q[i] !== exp_q[i] || rd_cyc_q[i] !== rd_cyc_q[0] + i) begin
        n_fail++;
        $display("FAIL %s_data[%0d]: got %h at cycle offset %0d expected %h at offset %0d",
                 name, i, rd_data_q[i], rd_cyc_q[i] - rd_cyc_q[0], exp_q[i], i);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || full !== exp_full || wr_addr_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_end: got busy=%b full=%b writes=%0d expected busy=0 full=%b writes=0",
               name, busy, full, wr_addr_q.size(), exp_full);
    end
  endtask

  task automatic test_partial_then_read();
    stim_q = '{16'h0011, 16'h0022, 16'h0033};
    test_capture("partial", 1'b0);
    test_readout("partial_read");
  endtask

  task automatic test_full_capture();
    fill_random(10);
    test_capture("full", 1'b0);
    test_readout("full_read");
  endtask

  task automatic test_random_captures();
    for (int k = 0; k < 5; k++) begin
      fill_random($urandom_range(1, 12));
      test_capture("rand", 1'b1);
      test_readout("rand_read");
    end
  endtask

  task automatic test_simultaneous_edges();
    logic [NB_DATA-1:0] x;
    stim_q = '{16'h0aa1, 16'h0aa2, 16'h0aa3};
    test_capture("pre_sim", 1'b0);
    clear_mon();
    run  = 1'b1;
    read = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_enter_log: got busy=%b full=%b expected busy=1 full=0", busy, full);
    end
    x = NB_DATA'($urandom);
    valid = 1'b1;
    data  = x;
    tick();
    valid = 1'b0;
    run   = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (rd_data_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sim_no_readout: got %0d outputs expected 0", rd_data_q.size());
    end
    n_checks++;
    if (wr_addr_q.size() !== 1 || (wr_addr_q.size() > 0 && (wr_addr_q[0] !== 0 || wr_data_q[0] !== x))) begin
      n_fail++;
      $display("FAIL sim_write: got %0d writes expected 1 write of %h at addr 0", wr_addr_q.size(), x);
    end
    read = 1'b0;
    tick();
    exp_q.delete();
    exp_q.push_back(x);
    exp_full = 1'b0;
    test_readout("sim_read");
  endtask

  task automatic test_reset_mid_read();
    logic [2*NB_DATA+NB_ADDR+4:0] outs;
    fill_random(5);
    test_capture("pre_rst", 1'b0);
    clear_mon();
    read = 1'b1;
    for (int t = 0; t < 20 && rd_data_q.size() < 2; t++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (rd_data_q.size() !== 2) begin
      n_fail++;
      $display("FAIL rst_read_progress: got %0d outputs expected 2", rd_data_q.size());
    end
    rst = 1'b1;
    #1;
    outs = {mem_we, mem_addr, mem_wdata, out_data, out_valid, full, busy};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_read_outputs: got %h expected 0", outs);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (busy !== 1'b0 || rd_data_q.size() !== 2) begin
      n_fail++;
      $display("FAIL rst_after_release: got busy=%b outputs=%0d expected busy=0 outputs=2",
               busy, rd_data_q.size());
    end
    read = 1'b0;
    tick();
  endtask

  task automatic test_run_high_at_release();
    rst = 1'b1;
    run = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL release_run_edge: got busy=%b expected 1", busy);
    end
    run = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release_run_stop: got busy=%b expected 0", busy);
    end
  endtask

  // Counter is 0 here (capture with no samples), so a read edge is ignored.
  task automatic test_read_empty();
    clear_mon();
    read = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_busy[%0d]: got %b expected 0", t, busy);
      end
    end
    n_checks++;
    if (wr_addr_q.size() !== 0 || rd_data_q.size() !== 0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL empty_access: got writes=%0d outputs=%0d addr=%0d expected 0 0 0",
               wr_addr_q.size(), rd_data_q.size(), mem_addr);
    end
    read = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_partial_then_read();
    test_full_capture();
    test_random_captures();
    test_simultaneous_edges();
    test_reset_mid_read();
    test_run_high_at_release();
    test_read_empty();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
